// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_DONE
   } state_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_SHIFT     = 2;

   function automatic logic [31:0] word_to_byte_addr(input logic [31:0] w);
      return w << WORD_SHIFT;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface imem_loader_if;

   logic        in_byte_valid;
   logic [7:0]  in_byte_data;
   logic        out_byte_ready;
   logic        out_imem_we;
   logic [31:0] out_imem_addr;
   logic [31:0] out_imem_wdata;

   modport master (
      output in_byte_valid,
      output in_byte_data,
      input  out_byte_ready,
      input  out_imem_we,
      input  out_imem_addr,
      input  out_imem_wdata
   );

   modport slave (
      input  in_byte_valid,
      input  in_byte_data,
      output out_byte_ready,
      output out_imem_we,
      output out_imem_addr,
      output out_imem_wdata
   );

endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        complete_o
);

   localparam int IW = $clog2(BYTES_PER_WORD);
   localparam logic [IW-1:0] LAST = IW'(BYTES_PER_WORD - 1);

   logic [IW-1:0] idx_q, idx_d;
   logic [31:0]   sr_q, sr_d;
   logic [31:0]   word_q, word_d;
   logic [31:0]   ins;
   logic          last;

   always_comb begin
      last   = (idx_q == LAST);
      ins    = sr_q;
      ins[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d  = idx_q;
      sr_d   = sr_q;
      word_d = word_q;
      if (clear_i) begin
         idx_d = '0;
         sr_d  = '0;
      end else if (accept_i) begin
         sr_d  = ins;
         idx_d = idx_q + 1'b1;
         // Output word only changes on completion so it stays stable between writes
         if (last) word_d = ins;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         sr_q   <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         sr_q   <= sr_d;
         word_q <= word_d;
      end
   end

   assign word_o     = word_q;
   assign complete_o = accept_i && !clear_i && last;

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory while holding the CPU in reset.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_start,
   input  logic [ADDR_WIDTH:0] in_word_count,
   imem_loader_if.slave        bus,
   output logic                out_cpu_hold,
   output logic                out_busy,
   output logic                out_done,
   output logic                out_error
);

   localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_e                state_q, state_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [ADDR_WIDTH:0]   target_q, target_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  error_q, error_d;
   logic                  clear;
   logic                  accept;
   logic                  complete;
   logic [31:0]           word;

   assign accept = bus.in_byte_valid && bus.out_byte_ready;

   imem_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear),
      .accept_i   (accept),
      .byte_i     (bus.in_byte_data),
      .word_o     (word),
      .complete_o (complete)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      addr_d   = addr_q;
      error_d  = error_q;
      clear    = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (in_start) begin
               if (in_word_count == '0) begin
                  state_d = S_DONE;
                  error_d = 1'b0;
               end else if (in_word_count > CAP) begin
                  error_d = 1'b1;
               end else begin
                  state_d  = S_COLLECT;
                  cnt_d    = '0;
                  target_d = in_word_count;
                  error_d  = 1'b0;
                  clear    = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            if (in_start) error_d = 1'b1;
            if (complete) begin
               state_d = S_WRITE;
               addr_d  = cnt_q[ADDR_WIDTH-1:0];
            end
         end
         S_WRITE: begin
            if (in_start) error_d = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == target_q) state_d = S_DONE;
            else                          state_d = S_COLLECT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         target_q <= '0;
         addr_q   <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         addr_q   <= addr_d;
         error_q  <= error_d;
      end
   end

   assign bus.out_byte_ready = (state_q == S_COLLECT);
   assign bus.out_imem_we    = (state_q == S_WRITE);
   assign bus.out_imem_addr  = word_to_byte_addr(32'(addr_q));
   assign bus.out_imem_wdata = word;

   assign out_cpu_hold = (state_q != S_DONE);
   assign out_busy     = (state_q == S_COLLECT) || (state_q == S_WRITE);
   assign out_done     = (state_q == S_DONE);
   assign out_error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_WIDTH=2).
module tb_imem_loader;

   localparam int AW = 2;

   logic          clk   = 1'b0;
   logic          rst   = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   count = '0;
   logic          hold, busy, done, err;

   imem_loader_if bus();

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_start      (start),
      .in_word_count (count),
      .bus           (bus.slave),
      .out_cpu_hold  (hold),
      .out_busy      (busy),
      .out_done      (done),
      .out_error     (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] wa[$];
   logic [31:0] wd[$];
   logic [7:0]  txq[$];

   always @(negedge clk) begin
      if (bus.out_imem_we) begin
         wa.push_back(bus.out_imem_addr);
         wd.push_back(bus.out_imem_wdata);
      end
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [AW:0] c);
      start = 1'b1;
      count = c;
      tick();
      start = 1'b0;
   endtask

   task automatic push4(input logic [31:0] w);
      for (int i = 0; i < 4; i++) txq.push_back(w[8*i +: 8]);
   endtask

   task automatic send(input bit stall);
      int g;
      while (txq.size() > 0) begin
         if (stall) begin
            bus.in_byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
         bus.in_byte_valid = 1'b1;
         bus.in_byte_data  = txq.pop_front();
         g = 0;
         while (!bus.out_byte_ready && g < 50) begin
            tick();
            g++;
         end
         if (!bus.out_byte_ready) begin
            chk1("ready_timeout", bus.out_byte_ready, 1'b1);
            txq.delete();
         end else begin
            tick();
         end
      end
      bus.in_byte_valid = 1'b0;
   endtask

   task automatic wait_done();
      int g = 0;
      while (!done && g < 100) begin
         tick();
         g++;
      end
      chk1("done_wait", done, 1'b1);
   endtask

   task automatic chk_write(input int i, input logic [31:0] ea,
                            input logic [31:0] ed);
      if (i < wa.size()) begin
         chk32($sformatf("waddr%0d", i), wa[i], ea);
         chk32($sformatf("wdata%0d", i), wd[i], ed);
      end else begin
         chk32($sformatf("wmissing%0d", i), 32'(wa.size()), 32'(i + 1));
      end
   endtask

   task automatic chk_nwrites(input string tag, input int n);
      chk32(tag, 32'(wa.size()), 32'(n));
   endtask

   task automatic clear_writes();
      wa.delete();
      wd.delete();
   endtask

   int s;

   initial begin
      bus.in_byte_valid = 1'b0;
      bus.in_byte_data  = 8'h00;

      // reset state
      #1 rst = 1'b1;
      #1;
      chk1("rst_hold", hold, 1'b1);
      chk1("rst_ready", bus.out_byte_ready, 1'b0);
      chk1("rst_we", bus.out_imem_we, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_error", err, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk32("rst_addr", bus.out_imem_addr, 32'h0);
      chk32("rst_wdata", bus.out_imem_wdata, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      repeat (10) tick();
      chk1("idle_hold", hold, 1'b1);
      chk1("idle_ready", bus.out_byte_ready, 1'b0);
      chk1("idle_we", bus.out_imem_we, 1'b0);
      chk1("idle_done", done, 1'b0);
      chk1("idle_error", err, 1'b0);
      chk_nwrites("idle_nwrites", 0);

      // two-word load, valid held high
      pulse_start(3'd2);
      s = cyc;
      chk1("start_ready", bus.out_byte_ready, 1'b1);
      chk1("start_busy", busy, 1'b1);
      push4(32'h00000013);
      push4(32'h002080B3);
      send(1'b0);
      chk1("w2_we", bus.out_imem_we, 1'b1);
      chk32("w2_addr_live", bus.out_imem_addr, 32'h4);
      chk32("w2_data_live", bus.out_imem_wdata, 32'h002080B3);
      tick();
      chk1("w2_done", done, 1'b1);
      chk1("w2_hold", hold, 1'b0);
      chk1("w2_we_off", bus.out_imem_we, 1'b0);
      chk1("w2_ready_off", bus.out_byte_ready, 1'b0);
      chk32("w2_cycles", 32'(cyc - s), 32'd10);
      chk32("w2_addr_held", bus.out_imem_addr, 32'h4);
      chk32("w2_data_held", bus.out_imem_wdata, 32'h002080B3);
      chk_nwrites("w2_nwrites", 2);
      chk_write(0, 32'h0, 32'h00000013);
      chk_write(1, 32'h4, 32'h002080B3);
      clear_writes();

      // same stream with stalls, restarted from DONE
      pulse_start(3'd2);
      chk1("stall_hold", hold, 1'b1);
      chk1("stall_done_off", done, 1'b0);
      push4(32'h00000013);
      push4(32'h002080B3);
      send(1'b1);
      wait_done();
      repeat (3) tick();
      chk_nwrites("stall_nwrites", 2);
      chk_write(0, 32'h0, 32'h00000013);
      chk_write(1, 32'h4, 32'h002080B3);
      clear_writes();

      // count 0 goes straight to DONE
      pulse_start(3'd0);
      chk1("zero_done", done, 1'b1);
      chk1("zero_busy", busy, 1'b0);
      repeat (3) tick();
      chk_nwrites("zero_nwrites", 0);

      // oversized count from IDLE
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      pulse_start(3'd5);
      chk1("big_error", err, 1'b1);
      chk1("big_hold", hold, 1'b1);
      chk1("big_busy", busy, 1'b0);
      chk1("big_ready", bus.out_byte_ready, 1'b0);
      chk1("big_done", done, 1'b0);

      // start during a load
      pulse_start(3'd1);
      chk1("err_cleared", err, 1'b0);
      txq.push_back(8'h11);
      txq.push_back(8'h22);
      send(1'b0);
      pulse_start(3'd3);
      chk1("mid_error", err, 1'b1);
      chk1("mid_busy", busy, 1'b1);
      txq.push_back(8'h33);
      txq.push_back(8'h44);
      send(1'b0);
      wait_done();
      chk1("mid_err_sticky", err, 1'b1);
      chk_nwrites("mid_nwrites", 1);
      chk_write(0, 32'h0, 32'h44332211);
      clear_writes();

      // reset after two bytes
      pulse_start(3'd1);
      chk1("restart_err_clr", err, 1'b0);
      txq.push_back(8'hAA);
      txq.push_back(8'hBB);
      send(1'b0);
      rst = 1'b1;
      #1;
      chk1("mrst_busy", busy, 1'b0);
      chk1("mrst_hold", hold, 1'b1);
      chk1("mrst_ready", bus.out_byte_ready, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk_nwrites("mrst_nwrites", 0);
      pulse_start(3'd1);
      push4(32'hCAFEF00D);
      send(1'b0);
      wait_done();
      chk_nwrites("fresh_nwrites", 1);
      chk_write(0, 32'h0, 32'hCAFEF00D);
      clear_writes();

      // full capacity, then restart from DONE
      pulse_start(3'd4);
      push4(32'h11111111);
      push4(32'h22222222);
      push4(32'h33333333);
      push4(32'h44444444);
      send(1'b0);
      wait_done();
      chk_nwrites("full_nwrites", 4);
      chk_write(0, 32'h0, 32'h11111111);
      chk_write(1, 32'h4, 32'h22222222);
      chk_write(2, 32'h8, 32'h33333333);
      chk_write(3, 32'hC, 32'h44444444);
      clear_writes();
      pulse_start(3'd1);
      chk1("reload_hold", hold, 1'b1);
      chk1("reload_ready", bus.out_byte_ready, 1'b1);
      push4(32'h00500093);
      send(1'b0);
      wait_done();
      chk_nwrites("reload_nwrites", 1);
      chk_write(0, 32'h0, 32'h00500093);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
